in256_out1536_pack: RTL and testbench

//  Upstream packer for the inter-switch inputs. Collects 256-bit AXI-Stream beats

---
 rtl/in256_out1536_pack_pkg.sv | 32 +++
 rtl/in256_out1536_pack.sv | 125 ++++++++++++
 tb/tb_in256_out1536_pack.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/in256_out1536_pack_pkg.sv
// ============================================================================
// Module  : in256_out1536_pack_pkg
// Brief   : Shared lane geometry and helper functions for the 256/1536 packers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package in256_out1536_pack_pkg;

    localparam int c_IN_W  = 256;
    localparam int c_RATIO = 6;
    localparam int c_OUT_W = c_IN_W * c_RATIO;
    localparam int c_IDX_W = 3;

    // One-hot lane write-enable decoded from a lane index.
    function automatic logic [c_RATIO-1:0] lane_sel(input logic [c_IDX_W-1:0] idx);
        lane_sel = '0;
        for (int k = 0; k < c_RATIO; k++) begin
            if (idx == c_IDX_W'(k)) begin
                lane_sel[k] = 1'b1;
            end
        end
    endfunction

    // Beat counts 1..RATIO are legal; anything else falls back to RATIO.
    function automatic logic cfg_legal(input logic [c_IDX_W-1:0] cfg);
        return (cfg != '0) && (cfg <= c_IDX_W'(c_RATIO));
    endfunction

endpackage

`default_nettype wire

// File: rtl/in256_out1536_pack.sv
// ============================================================================
// Module  : in256_out1536_pack
// Brief   : Packs 1..6 256-bit AXI-Stream beats into one zero-padded 1536-bit word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module in256_out1536_pack
    import in256_out1536_pack_pkg::*;
#(
    parameter int IN_W  = c_IN_W,
    parameter int RATIO = c_RATIO,
    parameter int OUT_W = c_OUT_W,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [c_IDX_W-1:0]  cfg_beats,
    input  logic [IN_W-1:0]     s_axis_tdata,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic [OUT_W-1:0]    m_axis_tdata,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    output logic [CNT_W-1:0]    word_cnt,
    output logic                cfg_err
);

    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] r_nb;
    logic [OUT_W-1:0]   r_out;
    logic               r_valid;
    logic               r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cfg_err;

    logic               w_in_take;
    logic               w_out_take;
    logic               w_start;
    logic               w_cfg_ok;
    logic               w_final;
    logic [c_IDX_W-1:0] w_nb;
    logic [RATIO-1:0]   w_lane_we;
    logic [OUT_W-1:0]   w_word;

    assign s_axis_tready = !r_valid || m_axis_tready;
    assign w_in_take     = s_axis_tvalid && s_axis_tready;
    assign w_out_take    = r_valid && m_axis_tready;
    assign w_start       = (r_idx == '0);
    assign w_cfg_ok      = cfg_legal(cfg_beats);
    assign w_lane_we     = lane_sel(r_idx);

    // The first beat of a word must already see the new beat count (nb=1 case).
    assign w_nb    = !w_start ? r_nb : (w_cfg_ok ? cfg_beats : c_IDX_W'(RATIO));
    assign w_final = s_axis_tlast || (r_idx == (w_nb - c_IDX_W'(1)));

    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        if (k < RATIO - 1) begin : g_acc
            logic [IN_W-1:0] r_lane;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lane <= '0;
                end else if (w_in_take) begin
                    if (w_final) begin
                        r_lane <= '0;
                    end else if (w_lane_we[k]) begin
                        r_lane <= s_axis_tdata;
                    end
                end
            end

            assign w_word[k*IN_W +: IN_W] = w_lane_we[k]              ? s_axis_tdata :
                                            (r_idx > c_IDX_W'(k))     ? r_lane       : '0;
        end else begin : g_top
            // The last lane is only ever written by a final beat, so it needs no storage.
            assign w_word[k*IN_W +: IN_W] = w_lane_we[k] ? s_axis_tdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_nb      <= c_IDX_W'(RATIO);
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_cnt     <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_in_take && w_start && !w_cfg_ok;

            if (w_out_take) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_in_take) begin
                if (w_start) begin
                    r_nb <= w_nb;
                end
                r_idx <= w_final ? '0 : r_idx + c_IDX_W'(1);
            end

            // A freshly closed word wins over the release of the previous one.
            if (w_in_take && w_final) begin
                r_out   <= w_word;
                r_valid <= 1'b1;
                r_last  <= s_axis_tlast;
            end else if (w_out_take) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_out;
    assign m_axis_tvalid = r_valid;
    assign m_axis_tlast  = r_last;
    assign word_cnt      = r_cnt;
    assign cfg_err       = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_in256_out1536_pack.sv
// ============================================================================
// Module  : tb_in256_out1536_pack
// Brief   : Self-checking bench for in256_out1536_pack with a queue-based word model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_in256_out1536_pack;

    localparam int IN_W  = 256;
    localparam int RATIO = 6;
    localparam int OUT_W = 1536;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        cfg_beats = 3'd6;
    logic [IN_W-1:0]   s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tready;
    logic [OUT_W-1:0]  m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready = 1'b1;
    logic [31:0]       word_cnt;
    logic              cfg_err;

    in256_out1536_pack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_beats     (cfg_beats),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .word_cnt      (word_cnt),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    longint cyc = 0;

    // Reference model: beats of the open word, and the words it must emit in order.
    logic [IN_W-1:0]  cur_q[$];
    int               cur_nb = 6;
    logic [OUT_W-1:0] exp_data_q[$];
    logic             exp_last_q[$];
    int               exp_err = 0;
    int               got_err = 0;
    int               got_words = 0;

    typedef struct {
        logic [2:0] cfg;
        int         nbeats;
        int         last_at;
        int         exp_words;
        int         exp_errs;
    } vec_t;

    vec_t vecs[7];

    task automatic check_int(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [OUT_W-1:0] act,
                              input logic [OUT_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            for (int k = 0; k < RATIO; k++) begin
                if (act[k*IN_W +: IN_W] !== exp[k*IN_W +: IN_W]) begin
                    $display("FAIL %s: lane %0d got %h want %h", name, k,
                             act[k*IN_W +: IN_W], exp[k*IN_W +: IN_W]);
                    break;
                end
            end
        end
    endtask

    function automatic void model_beat(input logic [IN_W-1:0] d, input logic last,
                                       input logic [2:0] cfg);
        logic [OUT_W-1:0] w;
        if (cur_q.size() == 0) begin
            if (cfg >= 3'd1 && cfg <= 3'd6) begin
                cur_nb = int'(cfg);
            end else begin
                cur_nb = 6;
                exp_err++;
            end
        end
        cur_q.push_back(d);
        if (cur_q.size() == cur_nb || last) begin
            w = '0;
            foreach (cur_q[i]) w[i*IN_W +: IN_W] = cur_q[i];
            exp_data_q.push_back(w);
            exp_last_q.push_back(last);
            cur_q.delete();
        end
    endfunction

    function automatic logic [IN_W-1:0] rand_beat();
        logic [IN_W-1:0] r;
        for (int i = 0; i < IN_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Output monitor: word order/content, AXI hold rule, ready rule, cfg_err pulses.
    initial begin
        logic [OUT_W-1:0] prev_data;
        logic             prev_last;
        logic             prev_stall;
        prev_data  = '0;
        prev_last  = 1'b0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_int("hold_valid", longint'(m_axis_tvalid), 1);
                    check_int("hold_last", longint'(m_axis_tlast), longint'(prev_last));
                    check_word("hold_data", m_axis_tdata, prev_data);
                end
                check_int("s_ready_rule", longint'(s_axis_tready),
                          longint'(!m_axis_tvalid || m_axis_tready));
                if (cfg_err) got_err++;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_data_q.size() == 0) begin
                        check_int("unexpected_word", 1, 0);
                    end else begin
                        check_word("word_data", m_axis_tdata, exp_data_q.pop_front());
                        check_int("word_last", longint'(m_axis_tlast),
                                  longint'(exp_last_q.pop_front()));
                    end
                    got_words++;
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic last, input logic [2:0] cfg);
        int waited;
        waited = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        cfg_beats     = cfg;
        @(negedge clk);
        while (!s_axis_tready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!s_axis_tready) begin
            check_int("send_timeout", 0, 1);
        end else begin
            model_beat(d, last, cfg);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic model_clear();
        cur_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
        exp_err   = 0;
        got_err   = 0;
        got_words = 0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        cfg_beats     = 3'd6;
        model_clear();
        idle(2);
        rst_n = 1'b1;
        check_int("rst_m_valid", longint'(m_axis_tvalid), 0);
        check_int("rst_m_last", longint'(m_axis_tlast), 0);
        check_word("rst_m_data", m_axis_tdata, '0);
        check_int("rst_word_cnt", longint'(word_cnt), 0);
        check_int("rst_cfg_err", longint'(cfg_err), 0);
        check_int("rst_s_ready", longint'(s_axis_tready), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_axis_tready = 1'b1;
        do begin
            idle(1);
            n++;
        end while ((exp_data_q.size() != 0 || m_axis_tvalid) && n < 200);
        check_int("drain_done", longint'(exp_data_q.size()), 0);
    endtask

    initial begin
        logic [IN_W-1:0]  d;
        logic [OUT_W-1:0] w;
        longint           c0;
        bit               done;

        vecs[0] = '{cfg: 3'd3, nbeats: 9,  last_at: -1, exp_words: 3, exp_errs: 0};
        vecs[1] = '{cfg: 3'd6, nbeats: 9,  last_at: 2,  exp_words: 2, exp_errs: 0};
        vecs[2] = '{cfg: 3'd1, nbeats: 4,  last_at: -1, exp_words: 4, exp_errs: 0};
        vecs[3] = '{cfg: 3'd0, nbeats: 6,  last_at: -1, exp_words: 1, exp_errs: 1};
        vecs[4] = '{cfg: 3'd7, nbeats: 12, last_at: -1, exp_words: 2, exp_errs: 2};
        vecs[5] = '{cfg: 3'd2, nbeats: 5,  last_at: 0,  exp_words: 3, exp_errs: 0};
        vecs[6] = '{cfg: 3'd5, nbeats: 7,  last_at: 6,  exp_words: 2, exp_errs: 0};

        // Full 6-beat word: latency and lane placement against a fixed pattern.
        do_reset();
        for (int b = 0; b < 6; b++) begin
            d = IN_W'(b + 1);
            send(d, 1'b0, 3'd6);
            if (b == 4) check_int("t1_no_early_valid", longint'(m_axis_tvalid), 0);
        end
        check_int("t1_valid_next_cycle", longint'(m_axis_tvalid), 1);
        check_int("t1_last", longint'(m_axis_tlast), 0);
        w = '0;
        for (int k = 0; k < RATIO; k++) w[k*IN_W +: IN_W] = IN_W'(k + 1);
        check_word("t1_word", m_axis_tdata, w);
        drain();
        check_int("t1_word_cnt", longint'(word_cnt), 1);

        // Back-to-back 3-beat words: nine beats in nine cycles.
        do_reset();
        c0 = cyc;
        for (int b = 0; b < 9; b++) send(rand_beat(), 1'b0, 3'd3);
        check_int("t2_cycles", cyc - c0, 9);
        drain();
        check_int("t2_word_cnt", longint'(word_cnt), 3);

        // Table of configurations / tlast positions.
        for (int t = 0; t < 7; t++) begin
            do_reset();
            for (int b = 0; b < vecs[t].nbeats; b++) begin
                d = '0;
                d[31:0]    = 32'(b + 1);
                d[255:224] = 32'(t + 16);
                send(d, (b == vecs[t].last_at), vecs[t].cfg);
            end
            drain();
            check_int("vec_words", longint'(got_words), longint'(vecs[t].exp_words));
            check_int("vec_word_cnt", longint'(word_cnt), longint'(vecs[t].exp_words));
            check_int("vec_cfg_err", longint'(got_err), longint'(vecs[t].exp_errs));
        end

        // Illegal cfg at word start, then a mid-word change that must be ignored.
        do_reset();
        for (int b = 0; b < 6; b++) send(rand_beat(), 1'b0, (b < 3) ? 3'd0 : 3'd2);
        drain();
        check_int("t5_words", longint'(got_words), 1);
        check_int("t5_cfg_err", longint'(got_err), 1);

        // Downstream stall for 20 cycles while beats keep arriving.
        do_reset();
        done = 1'b0;
        fork
            begin
                for (int b = 0; b < 24; b++) begin
                    send(rand_beat(), 1'b0, 3'd4);
                    idle($urandom_range(0, 2));
                end
            end
            begin
                idle(5);
                m_axis_tready = 1'b0;
                idle(20);
                check_int("t4_stall_valid", longint'(m_axis_tvalid), 1);
                check_int("t4_stall_s_ready", longint'(s_axis_tready), 0);
                m_axis_tready = 1'b1;
            end
        join
        drain();
        check_int("t4_words", longint'(got_words), 6);
        check_int("t4_word_cnt", longint'(word_cnt), 6);

        // Asynchronous reset in the middle of a word.
        do_reset();
        send(rand_beat(), 1'b1, 3'd6);
        idle(2);
        for (int b = 0; b < 4; b++) send(rand_beat(), 1'b0, 3'd6);
        check_int("t6_pre_cnt", longint'(word_cnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("t6_async_cnt", longint'(word_cnt), 0);
        check_word("t6_async_data", m_axis_tdata, '0);
        check_int("t6_async_valid", longint'(m_axis_tvalid), 0);
        model_clear();
        idle(2);
        rst_n = 1'b1;
        for (int b = 0; b < 6; b++) send(rand_beat(), 1'b0, 3'd6);
        drain();
        check_int("t6_words", longint'(got_words), 1);
        check_int("t6_word_cnt", longint'(word_cnt), 1);

        // Randomised traffic against the model.
        do_reset();
        done = 1'b0;
        fork
            begin
                for (int b = 0; b < 300; b++) begin
                    send(rand_beat(), ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)));
                    idle($urandom_range(0, 1));
                end
                send(rand_beat(), 1'b1, 3'd6);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    idle(1);
                    m_axis_tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        check_int("rnd_word_cnt", longint'(word_cnt), longint'(got_words));
        check_int("rnd_cfg_err", longint'(got_err), longint'(exp_err));
        check_int("rnd_partial", longint'(cur_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
